// File: rtl/wb_pkg.sv
// Shared types for the write-back buffer: drain FSM states and the buffer entry layout.
// Entry fields are sized to WB_MAX_WIDTH; instances use DATA_WIDTH <= WB_MAX_WIDTH.
package wb_pkg;

    localparam int WB_MAX_WIDTH = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic                    valid;
        logic [WB_MAX_WIDTH-1:0] addr;
        logic [WB_MAX_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// Address match across the buffer, returning the youngest valid matching entry.
// Entries are walked from the head (oldest) so a later match overrides an earlier one.
// i_excl_head masks the head slot when it is already in flight to memory.
module wb_match
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = 2
) (
    input  wb_entry_t [DEPTH-1:0]  i_entries,
    input  logic [PTR_W-1:0]       i_head,
    input  logic [DATA_WIDTH-1:0]  i_key,
    input  logic                   i_excl_head,
    output logic                   o_hit,
    output logic [PTR_W-1:0]       o_idx,
    output logic [DATA_WIDTH-1:0]  o_data
);

    logic [PTR_W-1:0] w_pos;
    logic             w_match;

    // Oldest-to-youngest scan; the last qualifying entry wins
    always_comb begin
        o_hit   = 1'b0;
        o_idx   = '0;
        o_data  = '0;
        w_pos   = i_head;
        w_match = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            w_pos   = i_head + PTR_W'(k);
            w_match = i_entries[w_pos].valid
                      && (i_entries[w_pos].addr == WB_MAX_WIDTH'(i_key))
                      && !(i_excl_head && (k == 0));
            o_idx   = w_match ? w_pos : o_idx;
            o_data  = w_match ? DATA_WIDTH'(i_entries[w_pos].data) : o_data;
            o_hit   = o_hit | w_match;
        end
    end

endmodule

// File: rtl/writeback_buffer.sv
// Write-back buffer between a cache and main memory: a circular FIFO of evicted
// lines that drains one entry at a time through a req/ack handshake, coalescing
// repeated evictions to the same address.
// Optional feature: define WB_FORWARD_EN to enable the rd_addr lookup path
// (rd_hit/rd_data); without it those outputs are tied to zero.
module writeback_buffer
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dirty_en,
    input  logic [DATA_WIDTH-1:0] dirty_add,
    input  logic [DATA_WIDTH-1:0] dirty_data,
    output logic                  full,
    input  logic [DATA_WIDTH-1:0] rd_addr,
    output logic                  rd_hit,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_ack
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t [DEPTH-1:0] r_entries;
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    wb_state_t             r_state;

    logic                  w_pop;
    logic                  w_accept;
    logic                  w_coal;
    logic                  w_append;
    logic [CNT_W-1:0]      w_count_nxt;
    logic                  w_cm_hit;
    logic [PTR_W-1:0]      w_cm_idx;
    logic [DATA_WIDTH-1:0] w_unused_cm_data;

    // The head is in flight while draining, so it is excluded from coalescing then
    wb_match #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_coalesce (
        .i_entries   (r_entries),
        .i_head      (r_head),
        .i_key       (dirty_add),
        .i_excl_head (r_state == DRAIN),
        .o_hit       (w_cm_hit),
        .o_idx       (w_cm_idx),
        .o_data      (w_unused_cm_data)
    );

    // A push needs a free slot, or the slot freed by a pop in the same cycle
    assign w_pop       = (r_state == DRAIN) && mem_ack;
    assign w_accept    = dirty_en && (!full || w_pop);
    assign w_coal      = w_accept && w_cm_hit;
    assign w_append    = w_accept && !w_cm_hit;
    assign w_count_nxt = r_count + CNT_W'(w_append) - CNT_W'(w_pop);

    assign full     = (r_count == CNT_W'(DEPTH));
    assign mem_req  = (r_state == DRAIN);
    assign mem_addr = mem_req ? DATA_WIDTH'(r_entries[r_head].addr) : '0;
    assign mem_data = mem_req ? DATA_WIDTH'(r_entries[r_head].data) : '0;

    // Storage and pointers: pop retires the head, append fills the tail (wins on shared slot)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_entries <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
        end else begin
            if (w_pop) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= r_head + PTR_W'(1);
            end
            if (w_coal) begin
                r_entries[w_cm_idx].data <= WB_MAX_WIDTH'(dirty_data);
            end
            if (w_append) begin
                r_entries[r_tail] <= '{valid: 1'b1,
                                       addr:  WB_MAX_WIDTH'(dirty_add),
                                       data:  WB_MAX_WIDTH'(dirty_data)};
                r_tail            <= r_tail + PTR_W'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // Drain controller: request memory while entries remain, release when empty
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    r_state <= (r_count != '0) ? DRAIN : IDLE;
                DRAIN:   r_state <= (w_count_nxt != '0) ? DRAIN : IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef WB_FORWARD_EN
    logic                  w_fw_hit;
    logic [PTR_W-1:0]      w_unused_fw_idx;
    logic [DATA_WIDTH-1:0] w_fw_data;

    // Fill lookup sees every valid entry, including a head that is in flight
    wb_match #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_lookup (
        .i_entries   (r_entries),
        .i_head      (r_head),
        .i_key       (rd_addr),
        .i_excl_head (1'b0),
        .o_hit       (w_fw_hit),
        .o_idx       (w_unused_fw_idx),
        .o_data      (w_fw_data)
    );

    assign rd_hit  = w_fw_hit;
    assign rd_data = w_fw_hit ? w_fw_data : '0;
`else
    logic w_unused_rd_addr;

    assign w_unused_rd_addr = ^rd_addr;
    assign rd_hit           = 1'b0;
    assign rd_data          = '0;
`endif

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed self-checking bench for writeback_buffer (DEPTH=4, DATA_WIDTH=32).
module tb_writeback_buffer;

    localparam int DW = 32;

`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dirty_en = 1'b0;
    logic [DW-1:0] dirty_add = '0;
    logic [DW-1:0] dirty_data = '0;
    logic          full;
    logic [DW-1:0] rd_addr = '0;
    logic          rd_hit;
    logic [DW-1:0] rd_data;
    logic          mem_req;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_ack = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    bit   mdrain = 1'b0;

    always #5 clk = ~clk;

    writeback_buffer #(.DATA_WIDTH(DW), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .dirty_en   (dirty_en),
        .dirty_add  (dirty_add),
        .dirty_data (dirty_data),
        .full       (full),
        .rd_addr    (rd_addr),
        .rd_hit     (rd_hit),
        .rd_data    (rd_data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ack    (mem_ack)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        dirty_en   = 1'b1;
        dirty_add  = a;
        dirty_data = d;
        cyc();
        dirty_en   = 1'b0;
    endtask

    task automatic drain_expect(input string tag, input logic [31:0] a, input logic [31:0] d);
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_addr"}, mem_addr, a);
        chk({tag, "_data"}, mem_data, d);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [31:0] a, input logic h, input logic [31:0] d);
        rd_addr = a;
        #1;
        chk({tag, "_hit"}, 32'(rd_hit), 32'(h));
        chk({tag, "_data"}, rd_data, d);
    endtask

    // One cycle of stimulus checked against a queue model of the buffer
    task automatic model_cycle(input bit en, input bit ack, input logic [31:0] a, input logic [31:0] d);
        int  sz;
        int  hit_j;
        bit  pop;
        bit  acc;
        dirty_en   = en;
        dirty_add  = a;
        dirty_data = d;
        mem_ack    = ack;
        #1;
        chk("rnd_req", 32'(mem_req), 32'(mdrain));
        chk("rnd_full", 32'(full), 32'(q.size() == 4));
        if (mdrain) begin
            chk("rnd_addr", mem_addr, q[0].a);
            chk("rnd_data", mem_data, q[0].d);
        end
        sz    = q.size();
        pop   = mdrain && ack;
        acc   = en && ((sz < 4) || pop);
        hit_j = -1;
        if (acc) begin
            for (int j = (mdrain ? 1 : 0); j < sz; j++) begin
                if (q[j].a == a) hit_j = j;
            end
        end
        if (acc && hit_j >= 0) q[hit_j].d = d;
        if (pop) void'(q.pop_front());
        if (acc && hit_j < 0) q.push_back('{a, d});
        mdrain = mdrain ? (q.size() > 0) : (sz > 0);
        cyc();
        dirty_en = 1'b0;
        mem_ack  = 1'b0;
    endtask

    initial begin
        // Reset and reset-state outputs
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_hit", 32'(rd_hit), 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        chk("rst_mdata", mem_data, 32'd0);
        chk("rst_rdata", rd_data, 32'd0);

        // Single push, request held while memory stalls, released after one ack
        push(32'h100, 32'hAAAA);
        chk("p1_idle_req", 32'(mem_req), 32'd0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("p1_req", 32'(mem_req), 32'd1);
            chk("p1_addr", mem_addr, 32'h100);
            chk("p1_data", mem_data, 32'hAAAA);
            if (i < 4) cyc();
        end
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk("p1_done_req", 32'(mem_req), 32'd0);

        // Fill to full, drop while stalled, accept alongside a pop
        push(32'h10, 32'd1);
        push(32'h11, 32'd2);
        push(32'h12, 32'd3);
        chk("f_not_full", 32'(full), 32'd0);
        push(32'h13, 32'd4);
        chk("f_full", 32'(full), 32'd1);
        push(32'h14, 32'd5);
        chk("f_drop_full", 32'(full), 32'd1);
        dirty_en   = 1'b1;
        dirty_add  = 32'h14;
        dirty_data = 32'd5;
        mem_ack    = 1'b1;
        cyc();
        dirty_en   = 1'b0;
        mem_ack    = 1'b0;
        chk("f_swap_full", 32'(full), 32'd1);
        drain_expect("f_d0", 32'h11, 32'd2);
        drain_expect("f_d1", 32'h12, 32'd3);
        drain_expect("f_d2", 32'h13, 32'd4);
        drain_expect("f_d3", 32'h14, 32'd5);
        chk("f_end_req", 32'(mem_req), 32'd0);
        chk("f_end_full", 32'(full), 32'd0);

        // Coalesce behind an in-flight head; same-address-as-head appends
        push(32'h100, 32'hA);
        cyc();
        chk("c_req", 32'(mem_req), 32'd1);
        push(32'h200, 32'd1);
        push(32'h200, 32'd2);
        push(32'h100, 32'd3);
        chk("c_full", 32'(full), 32'd0);
        chk("c_head_addr", mem_addr, 32'h100);
        chk("c_head_data", mem_data, 32'hA);
        lookup("c_lk200", 32'h200, FWD, FWD ? 32'd2 : 32'd0);
        lookup("c_lk100_young", 32'h100, FWD, FWD ? 32'd3 : 32'd0);
        drain_expect("c_d0", 32'h100, 32'hA);
        drain_expect("c_d1", 32'h200, 32'd2);
        drain_expect("c_d2", 32'h100, 32'd3);
        chk("c_end_req", 32'(mem_req), 32'd0);

        // Lookup hit and miss
        push(32'h100, 32'd5);
        push(32'h200, 32'd6);
        lookup("l_200", 32'h200, FWD, FWD ? 32'd6 : 32'd0);
        lookup("l_300", 32'h300, 1'b0, 32'd0);
        lookup("l_100", 32'h100, FWD, FWD ? 32'd5 : 32'd0);
        drain_expect("l_d0", 32'h100, 32'd5);
        drain_expect("l_d1", 32'h200, 32'd6);
        chk("l_end_req", 32'(mem_req), 32'd0);

        // Coalesce into the head while still idle
        push(32'h300, 32'd1);
        push(32'h300, 32'd2);
        drain_expect("h_d0", 32'h300, 32'd2);
        chk("h_end_req", 32'(mem_req), 32'd0);

        // Reset while draining three entries, with an eviction in the reset cycle
        push(32'h1, 32'h11);
        push(32'h2, 32'h22);
        push(32'h3, 32'h33);
        chk("r_pre_req", 32'(mem_req), 32'd1);
        rst        = 1'b1;
        dirty_en   = 1'b1;
        dirty_add  = 32'h99;
        dirty_data = 32'd9;
        cyc();
        rst        = 1'b0;
        dirty_en   = 1'b0;
        chk("r_req", 32'(mem_req), 32'd0);
        chk("r_full", 32'(full), 32'd0);
        chk("r_maddr", mem_addr, 32'd0);
        lookup("r_lk", 32'h2, 1'b0, 32'd0);
        cyc();
        chk("r_still_idle", 32'(mem_req), 32'd0);
        push(32'h40, 32'd7);
        cyc();
        drain_expect("r_d0", 32'h40, 32'd7);
        chk("r_end_req", 32'(mem_req), 32'd0);

        // Random ack traffic against the queue model, then drain out
        for (int i = 0; i < 20; i++) begin
            model_cycle($urandom_range(0, 3) != 0,
                        $urandom_range(0, 1) == 1,
                        32'h500 + 32'(4 * $urandom_range(0, 2)),
                        32'(i + 100));
        end
        for (int i = 0; i < 12; i++) begin
            model_cycle(1'b0, 1'b1, 32'h0, 32'h0);
        end
        chk("m_end_req", 32'(mem_req), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
